// File: rtl/vram_ctrl.sv
// VRAM arbiter: one memory port shared between CPU read/write and scanout reads.
// Define VRAM_VGA_PRIORITY_EN to give scanout absolute priority; otherwise ties are round-robin.
module vram_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] vram_cpu_addr,
    input  logic [31:0] vram_cpu_data_in,
    output logic [31:0] vram_cpu_data_out,
    input  logic        vram_cpu_req,
    input  logic        vram_cpu_write,
    output logic        vram_cpu_ready,
    output logic        vram_cpu_done,
    input  logic [14:0] vram_vga_addr,
    input  logic        vram_vga_req,
    output logic [31:0] vram_vga_data_out,
    output logic        vram_vga_ready,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic        mem_oe,
    output logic        mem_we
);

    typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, VGA_RD, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_vga_q;
    logic [14:0] mem_addr_q;
    logic [31:0] mem_data_out_q;
    logic        mem_oe_q;
    logic        mem_we_q;
    logic [31:0] cpu_data_out_q;
    logic [31:0] vga_data_out_q;
    logic        cpu_ready_q;
    logic        cpu_done_q;
    logic        vga_ready_q;

    logic cpu_pend;
    logic pick_vga;

    assign cpu_pend = vram_cpu_write | vram_cpu_req;

`ifdef VRAM_VGA_PRIORITY_EN
    assign pick_vga = vram_vga_req;
`else
    // On a tie, scanout goes only if the CPU was granted last.
    assign pick_vga = vram_vga_req & (~cpu_pend | ~last_vga_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_vga_q     <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            mem_oe_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            cpu_data_out_q <= '0;
            vga_data_out_q <= '0;
            cpu_ready_q    <= 1'b0;
            cpu_done_q     <= 1'b0;
            vga_ready_q    <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            cpu_done_q  <= 1'b0;
            vga_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pick_vga) begin
                        state_q    <= VGA_RD;
                        mem_addr_q <= vram_vga_addr;
                        mem_oe_q   <= 1'b1;
                        last_vga_q <= 1'b1;
                    end else if (vram_cpu_write) begin
                        state_q        <= CPU_WR;
                        mem_addr_q     <= vram_cpu_addr;
                        mem_data_out_q <= vram_cpu_data_in;
                        mem_we_q       <= 1'b1;
                        last_vga_q     <= 1'b0;
                    end else if (vram_cpu_req) begin
                        state_q    <= CPU_RD;
                        mem_addr_q <= vram_cpu_addr;
                        mem_oe_q   <= 1'b1;
                        last_vga_q <= 1'b0;
                    end
                end
                CPU_RD, CPU_WR, VGA_RD: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= DONE;
                        mem_oe_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (state_q == CPU_RD) begin
                            cpu_data_out_q <= mem_data_in;
                            cpu_ready_q    <= 1'b1;
                        end else if (state_q == VGA_RD) begin
                            vga_data_out_q <= mem_data_in;
                            vga_ready_q    <= 1'b1;
                        end else begin
                            cpu_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                // Requests are ignored here so a requester can drop its level.
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr          = mem_addr_q;
    assign mem_data_out      = mem_data_out_q;
    assign mem_oe            = mem_oe_q;
    assign mem_we            = mem_we_q;
    assign vram_cpu_data_out = cpu_data_out_q;
    assign vram_vga_data_out = vga_data_out_q;
    assign vram_cpu_ready    = cpu_ready_q;
    assign vram_cpu_done     = cpu_done_q;
    assign vram_vga_ready    = vga_ready_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl with MEM_WAIT=2: writes, reads, arbitration, reset abort.
module tb_vram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] vram_cpu_addr = '0;
    logic [31:0] vram_cpu_data_in = '0;
    logic [31:0] vram_cpu_data_out;
    logic        vram_cpu_req = 1'b0;
    logic        vram_cpu_write = 1'b0;
    logic        vram_cpu_ready;
    logic        vram_cpu_done;
    logic [14:0] vram_vga_addr = '0;
    logic        vram_vga_req = 1'b0;
    logic [31:0] vram_vga_data_out;
    logic        vram_vga_ready;
    logic [14:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in = '0;
    logic        mem_oe;
    logic        mem_we;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int pulses;

    vram_ctrl #(.MEM_WAIT(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .vram_cpu_addr     (vram_cpu_addr),
        .vram_cpu_data_in  (vram_cpu_data_in),
        .vram_cpu_data_out (vram_cpu_data_out),
        .vram_cpu_req      (vram_cpu_req),
        .vram_cpu_write    (vram_cpu_write),
        .vram_cpu_ready    (vram_cpu_ready),
        .vram_cpu_done     (vram_cpu_done),
        .vram_vga_addr     (vram_vga_addr),
        .vram_vga_req      (vram_vga_req),
        .vram_vga_data_out (vram_vga_data_out),
        .vram_vga_ready    (vram_vga_ready),
        .mem_addr          (mem_addr),
        .mem_data_out      (mem_data_out),
        .mem_data_in       (mem_data_in),
        .mem_oe            (mem_oe),
        .mem_we            (mem_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_oe", 32'(mem_oe), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_mdo", mem_data_out, 32'd0);
        check("rst_pulses", 32'({vram_cpu_ready, vram_cpu_done, vram_vga_ready}), 32'd0);
        check("rst_cpu_do", vram_cpu_data_out, 32'd0);
        #9 reset = 1'b0;
        tick();

        // CPU write: two strobe cycles, then done pulse
        vram_cpu_addr = 15'o12345;
        vram_cpu_data_in = 32'hDEADBEEF;
        vram_cpu_write = 1'b1;
        tick();
        check("wr_we_c1", 32'(mem_we), 32'd1);
        check("wr_addr_c1", 32'(mem_addr), 32'(15'o12345));
        check("wr_data_c1", mem_data_out, 32'hDEADBEEF);
        check("wr_oe_c1", 32'(mem_oe), 32'd0);
        check("wr_done_c1", 32'(vram_cpu_done), 32'd0);
        tick();
        check("wr_we_c2", 32'(mem_we), 32'd1);
        check("wr_addr_c2", 32'(mem_addr), 32'(15'o12345));
        check("wr_done_c2", 32'(vram_cpu_done), 32'd0);
        tick();
        check("wr_we_c3", 32'(mem_we), 32'd0);
        check("wr_done_c3", 32'(vram_cpu_done), 32'd1);
        vram_cpu_write = 1'b0;
        tick();
        check("wr_done_off", 32'(vram_cpu_done), 32'd0);
        tick();
        check("wr_idle_bus", 32'({mem_oe, mem_we}), 32'd0);

        // CPU read with data held after mem_data_in changes
        vram_cpu_addr = 15'o00777;
        mem_data_in = 32'h12345678;
        vram_cpu_req = 1'b1;
        tick();
        check("rd_oe_c1", 32'(mem_oe), 32'd1);
        check("rd_addr_c1", 32'(mem_addr), 32'(15'o00777));
        tick();
        check("rd_oe_c2", 32'(mem_oe), 32'd1);
        check("rd_ready_c2", 32'(vram_cpu_ready), 32'd0);
        tick();
        check("rd_oe_c3", 32'(mem_oe), 32'd0);
        check("rd_ready_c3", 32'(vram_cpu_ready), 32'd1);
        check("rd_data", vram_cpu_data_out, 32'h12345678);
        vram_cpu_req = 1'b0;
        mem_data_in = 32'h0;
        tick();
        check("rd_ready_off", 32'(vram_cpu_ready), 32'd0);
        check("rd_data_hold", vram_cpu_data_out, 32'h12345678);
        tick();
        check("rd_idle_bus", 32'(mem_oe), 32'd0);

        // Simultaneous CPU read and scanout: scanout first, then CPU
        vram_cpu_addr = 15'o200;
        vram_vga_addr = 15'o100;
        mem_data_in = 32'hA5A5A5A5;
        vram_cpu_req = 1'b1;
        vram_vga_req = 1'b1;
        tick();
        check("tie_first_addr", 32'(mem_addr), 32'(15'o100));
        tick();
        tick();
        check("tie_vga_ready", 32'(vram_vga_ready), 32'd1);
        check("tie_cpu_not_ready", 32'(vram_cpu_ready), 32'd0);
        check("tie_vga_data", vram_vga_data_out, 32'hA5A5A5A5);
        vram_vga_req = 1'b0;
        mem_data_in = 32'h5A5A5A5A;
        tick();
        tick();
        check("tie_second_addr", 32'(mem_addr), 32'(15'o200));
        tick();
        tick();
        check("tie_cpu_ready", 32'(vram_cpu_ready), 32'd1);
        check("tie_cpu_data", vram_cpu_data_out, 32'h5A5A5A5A);
        check("tie_vga_hold", vram_vga_data_out, 32'hA5A5A5A5);
        vram_cpu_req = 1'b0;
        tick();

        // Scanout held continuously with a pending CPU read
        vram_vga_addr = 15'o300;
        vram_cpu_addr = 15'o400;
        vram_vga_req = 1'b1;
        vram_cpu_req = 1'b1;
        tick();
        check("hold_g1_addr", 32'(mem_addr), 32'(15'o300));
        tick();
        tick();
        check("hold_g1_ready", 32'(vram_vga_ready), 32'd1);
        tick();
        tick();
`ifdef VRAM_VGA_PRIORITY_EN
        check("hold_g2_addr", 32'(mem_addr), 32'(15'o300));
        tick();
        tick();
        check("hold_g2_ready", 32'(vram_vga_ready), 32'd1);
`else
        check("hold_g2_addr", 32'(mem_addr), 32'(15'o400));
        tick();
        tick();
        check("hold_g2_ready", 32'(vram_cpu_ready), 32'd1);
        vram_cpu_req = 1'b0;
`endif
        tick();
        tick();
        check("hold_g3_addr", 32'(mem_addr), 32'(15'o300));
        check("hold_g3_oe", 32'(mem_oe), 32'd1);
        // Drop mid-access: must still complete
        vram_vga_req = 1'b0;
        vram_cpu_req = 1'b0;
        tick();
        tick();
        check("drop_mid_ready", 32'(vram_vga_ready), 32'd1);
        tick();
        tick();
        check("drop_idle_bus", 32'({mem_oe, mem_we}), 32'd0);

        // Reset during the second cycle of a write
        vram_cpu_addr = 15'o55;
        vram_cpu_data_in = 32'hCAFEF00D;
        vram_cpu_write = 1'b1;
        tick();
        check("rw_we_c1", 32'(mem_we), 32'd1);
        tick();
        check("rw_we_c2", 32'(mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rw_async_we", 32'(mem_we), 32'd0);
        check("rw_async_addr", 32'(mem_addr), 32'd0);
        check("rw_async_mdo", mem_data_out, 32'd0);
        check("rw_async_cpu_do", vram_cpu_data_out, 32'd0);
        check("rw_async_vga_do", vram_vga_data_out, 32'd0);
        vram_cpu_write = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (vram_cpu_done || mem_we) pulses++;
        end
        check("rw_no_done", 32'(pulses), 32'd0);

        // Tie right after reset: last-grant flag back to CPU, scanout wins
        vram_cpu_addr = 15'o200;
        vram_vga_addr = 15'o100;
        mem_data_in = 32'h0BADF00D;
        vram_cpu_req = 1'b1;
        vram_vga_req = 1'b1;
        tick();
        check("rst_tie_addr", 32'(mem_addr), 32'(15'o100));
        vram_cpu_req = 1'b0;
        vram_vga_req = 1'b0;
        tick();
        tick();
        check("rst_tie_ready", 32'(vram_vga_ready), 32'd1);
        check("rst_tie_data", vram_vga_data_out, 32'h0BADF00D);
        tick();
        tick();
        check("rst_tie_idle", 32'({mem_oe, mem_we}), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
